// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one word read in flight
// and hands each fetched word to decode over valid/ready, with redirect and halt.
module instr_fetch #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_WIDTH-1:0]  mem_req_addr,
   input  logic                   mem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_data,
   output logic [7:0]             instr_opcode,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   input  logic                   halt,
   output logic                   halted
);

   // Handshake rule on both sides: a transfer happens in a cycle where valid
   // and ready are both high at the rising edge; valid never depends on ready.
   typedef enum logic [1:0] {
      S_REQ    = 2'd0,
      S_WAIT   = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ADDR_WIDTH-1:0]  pc;
   logic                   drop;
   logic [INSTR_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0]  pc_q;
   logic                   active;

   // Halt overrides everything; once halted only rst brings the stage back.
   assign active = !halt && (state != S_HALTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!active) begin
         state_nxt = S_HALTED;
      end else begin
         case (state)
            S_REQ: begin
               if (mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (mem_rsp_valid) state_nxt = (drop || redirect_valid) ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
               if (redirect_valid || instr_ready) state_nxt = S_REQ;
            end
            default: state_nxt = S_HALTED;
         endcase
      end
   end

   always_comb begin
      mem_req_valid = (state == S_REQ);
      instr_valid   = (state == S_HOLD);
      halted        = (state == S_HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         drop   <= 1'b0;
         data_q <= '0;
         pc_q   <= '0;
      end else if (active) begin
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
                  // the old-address request still went out; its data must be thrown away
                  if (mem_req_ready) drop <= 1'b1;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  drop <= 1'b0;
                  if (redirect_valid) begin
                     pc <= redirect_pc;
                  end else if (!drop) begin
                     data_q <= mem_rsp_data;
                     pc_q   <= pc;
                     pc     <= pc + ADDR_WIDTH'(1);
                  end
               end else if (redirect_valid) begin
                  pc   <= redirect_pc;
                  drop <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect_valid) pc <= redirect_pc;
            end
            default: ;
         endcase
      end
   end

   assign mem_req_addr = pc;
   assign instr_data   = data_q;
   assign instr_pc     = pc_q;
   assign instr_opcode = data_q[INSTR_WIDTH-1 -: 8];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory latency, backpressure, redirects and
// halts checked against a next-expected-PC reference model and a wrap instance.
module tb_instr_fetch;
   localparam int AW = 16;
   localparam int IW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          mem_req_valid, mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_rsp_valid;
   logic [IW-1:0] mem_rsp_data;
   logic          instr_valid, instr_ready;
   logic [IW-1:0] instr_data;
   logic [7:0]    instr_opcode;
   logic [AW-1:0] instr_pc;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          halt, halted;

   logic          w_req_valid, w_req_ready;
   logic [AW-1:0] w_req_addr;
   logic          w_rsp_valid;
   logic [IW-1:0] w_rsp_data;
   logic          w_instr_valid, w_instr_ready;
   logic [IW-1:0] w_instr_data;
   logic [7:0]    w_instr_opcode;
   logic [AW-1:0] w_instr_pc;
   logic          w_redirect_valid, w_halt, w_halted;
   logic [AW-1:0] w_redirect_pc;

   instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(16'h0000)) u_dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .instr_opcode(instr_opcode), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .halted(halted)
   );

   instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(16'hFFFF)) u_wrap (
      .clk(clk), .rst(rst),
      .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
      .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
      .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr_data(w_instr_data),
      .instr_opcode(w_instr_opcode), .instr_pc(w_instr_pc),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .halt(w_halt), .halted(w_halted)
   );

   logic [IW-1:0] rom [256];
   logic [AW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // memory models
   bit            mem_busy;
   int            mem_lat;
   logic [AW-1:0] mem_addr;
   bit            w_pend;
   logic [AW-1:0] w_addr;

   // stimulus knobs
   int          lat_min, lat_max, irdy_mode;
   int unsigned req_rdy_pct, redir_pct;
   bit          force_redir, force_halt;
   logic [AW-1:0] force_redir_pc;

   // reference model: address of the next instruction decode should accept
   logic [AW-1:0] exp_next;
   bit            model_halted, prev_hold, last_iv;
   logic [IW-1:0] prev_data;
   logic [AW-1:0] prev_pc;
   int            n_consumed;
   logic [AW-1:0] cons_q[$], req_addr_q[$];
   int            req_cyc_q[$], rsp_cyc_q[$], vrise_q[$];

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return rom[a[7:0]] ^ {16'h0000, a};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle();
      logic [AW-1:0] e;
      logic [IW-1:0] w;
      @(posedge clk);
      #1;
      mem_rsp_valid = mem_busy && (mem_lat == 0);
      mem_rsp_data  = mem_rsp_valid ? mem_word(mem_addr) : IW'($urandom);
      mem_req_ready = ($urandom_range(0, 99) < req_rdy_pct);
      case (irdy_mode)
         0:       instr_ready = 1'b1;
         2:       instr_ready = 1'b0;
         default: instr_ready = 1'($urandom_range(0, 1));
      endcase
      redirect_valid = force_redir || ($urandom_range(0, 99) < redir_pct);
      redirect_pc    = force_redir ? force_redir_pc : AW'($urandom);
      halt           = force_halt;
      w_req_ready    = 1'b1;
      w_rsp_valid    = w_pend;
      w_rsp_data     = mem_word(w_addr);
      @(negedge clk);
      cyc++;
      if (model_halted) begin
         check_eq("halted_flag", 64'(halted), 64'(1));
         check_eq("halted_no_instr", 64'(instr_valid), 64'(0));
         check_eq("halted_no_req", 64'(mem_req_valid), 64'(0));
      end
      if (prev_hold) begin
         check_eq("hold_valid", 64'(instr_valid), 64'(1));
         check_eq("hold_data", 64'(instr_data), 64'(prev_data));
         check_eq("hold_pc", 64'(instr_pc), 64'(prev_pc));
      end
      if (mem_req_valid) check_eq("req_addr", 64'(mem_req_addr), 64'(exp_next));
      if (instr_valid && !last_iv) vrise_q.push_back(cyc);
      last_iv = instr_valid;
      if (instr_valid && instr_ready && !redirect_valid && !halt) begin
         w = mem_word(exp_next);
         check_eq("instr_pc", 64'(instr_pc), 64'(exp_next));
         check_eq("instr_data", 64'(instr_data), 64'(w));
         check_eq("instr_opcode", 64'(instr_opcode), 64'(w[31:24]));
         cons_q.push_back(instr_pc);
         exp_next = exp_next + AW'(1);
         n_consumed++;
      end
      prev_hold = instr_valid && !instr_ready && !redirect_valid && !halt;
      prev_data = instr_data;
      prev_pc   = instr_pc;
      if (redirect_valid && !halt && !model_halted) exp_next = redirect_pc;
      if (halt) model_halted = 1'b1;
      if (mem_rsp_valid) begin
         mem_busy = 1'b0;
         rsp_cyc_q.push_back(cyc);
      end else if (mem_busy) begin
         mem_lat--;
      end
      if (mem_req_valid && mem_req_ready) begin
         check_eq("single_outstanding", 64'(mem_busy), 64'(0));
         mem_busy = 1'b1;
         mem_lat  = int'($urandom_range(lat_min, lat_max));
         mem_addr = mem_req_addr;
         req_addr_q.push_back(mem_req_addr);
         req_cyc_q.push_back(cyc);
      end
      if (w_instr_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("wrap_pc", 64'(w_instr_pc), 64'(e));
         check_eq("wrap_data", 64'(w_instr_data), 64'(mem_word(e)));
      end
      w_pend = w_req_valid && w_req_ready;
      if (w_pend) w_addr = w_req_addr;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
         instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
         w_req_ready = 1'b0; w_rsp_valid = 1'b0;
         @(negedge clk);
         cyc++;
      end
      mem_busy = 1'b0; w_pend = 1'b0; exp_next = 16'h0000; model_halted = 1'b0;
      prev_hold = 1'b0; last_iv = 1'b0; force_redir = 1'b0; force_halt = 1'b0; n_consumed = 0;
      cons_q.delete(); req_addr_q.delete(); req_cyc_q.delete(); rsp_cyc_q.delete(); vrise_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      cyc++;
      check_eq("rst_req_valid", 64'(mem_req_valid), 64'(1));
      check_eq("rst_req_addr", 64'(mem_req_addr), 64'(16'h0000));
      check_eq("rst_instr_valid", 64'(instr_valid), 64'(0));
      check_eq("rst_instr_data", 64'(instr_data), 64'(0));
      check_eq("rst_instr_pc", 64'(instr_pc), 64'(0));
      check_eq("rst_halted", 64'(halted), 64'(0));
      check_eq("rst_wrap_addr", 64'(w_req_addr), 64'(16'hFFFF));
   endtask

   task automatic set_knobs(input int lmin, input int lmax, input int unsigned rdy,
                            input int irdy, input int unsigned redir);
      lat_min = lmin; lat_max = lmax; req_rdy_pct = rdy; irdy_mode = irdy; redir_pct = redir;
   endtask

   initial begin
      bit found;
      int n_req, c_before;
      logic [AW-1:0] held_pc;
      for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; force_redir_pc = '0;
      w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_instr_ready = 1'b1;
      w_redirect_valid = 1'b0; w_redirect_pc = '0; w_halt = 1'b0; w_addr = '0; mem_addr = '0;
      set_knobs(0, 0, 100, 0, 0);

      // single-cycle memory, decode always ready; wrap instance runs alongside
      do_reset();
      exp_q = '{16'hFFFF, 16'h0000, 16'h0001};
      repeat (12) cycle();
      check_eq("t1_count", 64'(cons_q.size() >= 3), 64'(1));
      if (cons_q.size() >= 3)
         for (int i = 0; i < 3; i++) check_eq("t1_seq_pc", 64'(cons_q[i]), 64'(i));
      if (req_cyc_q.size() >= 3) begin
         check_eq("t1_issue_gap0", 64'(req_cyc_q[1] - req_cyc_q[0]), 64'(3));
         check_eq("t1_issue_gap1", 64'(req_cyc_q[2] - req_cyc_q[1]), 64'(3));
      end else check_eq("t1_req_count", 64'(req_cyc_q.size()), 64'(3));
      if (vrise_q.size() > 0 && rsp_cyc_q.size() > 0)
         check_eq("t1_latency", 64'(vrise_q[0] - rsp_cyc_q[0]), 64'(1));
      else check_eq("t1_latency_seen", 64'(0), 64'(1));
      check_eq("wrap_drained", 64'(exp_q.size()), 64'(0));

      // backpressure in HOLD
      set_knobs(0, 0, 100, 2, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = instr_valid;
      end
      check_eq("t2_hold_reached", 64'(found), 64'(1));
      held_pc = instr_pc;
      repeat (5) begin
         cycle();
         check_eq("t2_no_req", 64'(mem_req_valid), 64'(0));
         check_eq("t2_pc_stable", 64'(instr_pc), 64'(held_pc));
      end
      irdy_mode = 0;
      cycle();
      cycle();
      check_eq("t2_next_req_valid", 64'(mem_req_valid), 64'(1));
      check_eq("t2_next_req_addr", 64'(mem_req_addr), 64'(AW'(held_pc + AW'(1))));

      // redirect while a slow response is outstanding
      set_knobs(2, 2, 100, 0, 0);
      found = 1'b0;
      n_req = req_addr_q.size();
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = (req_addr_q.size() > n_req);
      end
      check_eq("t3_req_seen", 64'(found), 64'(1));
      force_redir = 1'b1; force_redir_pc = 16'h0040;
      n_req = req_addr_q.size(); c_before = n_consumed;
      cycle();
      force_redir = 1'b0;
      for (int i = 0; i < 30 && n_consumed == c_before; i++) cycle();
      check_eq("t3_consumed", 64'(n_consumed > c_before), 64'(1));
      if (n_consumed > c_before) check_eq("t3_first_pc", 64'(cons_q[c_before]), 64'(16'h0040));
      if (req_addr_q.size() > n_req) check_eq("t3_req_addr", 64'(req_addr_q[n_req]), 64'(16'h0040));
      else check_eq("t3_req_count", 64'(req_addr_q.size()), 64'(n_req + 1));

      // redirect in HOLD with decode ready in the same cycle
      set_knobs(0, 2, 100, 2, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = instr_valid;
      end
      check_eq("t4_hold_reached", 64'(found), 64'(1));
      c_before = n_consumed;
      force_redir = 1'b1; force_redir_pc = 16'h0ABC; irdy_mode = 0;
      cycle();
      force_redir = 1'b0;
      check_eq("t4_not_counted", 64'(n_consumed), 64'(c_before));
      cycle();
      check_eq("t4_instr_dropped", 64'(instr_valid), 64'(0));
      check_eq("t4_req_valid", 64'(mem_req_valid), 64'(1));
      check_eq("t4_req_addr", 64'(mem_req_addr), 64'(16'h0ABC));

      // halt with a request outstanding; late response and redirect are ignored
      set_knobs(2, 2, 100, 0, 0);
      found = 1'b0;
      n_req = req_addr_q.size();
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = (req_addr_q.size() > n_req);
      end
      check_eq("t5_req_seen", 64'(found), 64'(1));
      force_halt = 1'b1;
      cycle();
      force_halt = 1'b0;
      cycle();
      check_eq("t5_halted", 64'(halted), 64'(1));
      force_redir = 1'b1; force_redir_pc = 16'h0777;
      cycle();
      force_redir = 1'b0;
      repeat (6) cycle();
      check_eq("t5_late_rsp_seen", 64'(mem_busy), 64'(0));
      do_reset();

      // randomized episodes, each ending in a halt
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         set_knobs(0, 3, 70, 1, 8);
         repeat (250) cycle();
         force_halt = 1'b1;
         cycle();
         force_halt = 1'b0;
         repeat (4) cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
